counter_bn: RTL and testbench

//  Parametrised N-bit multi-mode counter built from 4-bit slices with a true carry/borrow chain.

---
 rtl/counter_bn.sv | 101 ++++++++++
 tb/tb_counter_bn.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/counter_bn.sv
// Multi-mode WIDTH-bit counter (up, down-1, down-3, load) built from rippled 4-bit slices,
// with per-slice carry/borrow flags, a whole-word wrap flag and optional saturation.
module counter_bn #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          SATURATE = 1'b0,
    localparam int unsigned NSLICE  = WIDTH / 4
) (
    input  logic              cnt_clk,
    input  logic              cnt_reset,
    input  logic              cnt_enable,
    input  logic [1:0]        cnt_mode,
    input  logic [WIDTH-1:0]  cnt_D,
    output logic [WIDTH-1:0]  cnt_Q,
    output logic              cnt_load,
    output logic              cnt_rco,
    output logic [NSLICE-1:0] cnt_src
);

    typedef enum logic [1:0] {
        ModeUp    = 2'b00,
        ModeDown1 = 2'b01,
        ModeDown3 = 2'b10,
        ModeLoad  = 2'b11
    } mode_e;

    logic [WIDTH-1:0]  q_q, q_d;
    logic              load_q, load_d;
    logic              rco_q, rco_d;
    logic [NSLICE-1:0] src_q, src_d;

    logic [WIDTH-1:0]  sum;
    logic [NSLICE-1:0] carries;
    logic              up;

    assign up = (mode_e'(cnt_mode) == ModeUp);

    // Ripple through the slices; slice 0 takes the step, the rest take the previous carry/borrow.
    always_comb begin
        logic [4:0] step;
        logic [4:0] addend;
        logic [4:0] s;
        logic       c;
        sum     = '0;
        carries = '0;
        c       = 1'b0;
        step    = (mode_e'(cnt_mode) == ModeDown3) ? 5'd3 : 5'd1;
        for (int i = 0; i < NSLICE; i++) begin
            addend = (i == 0) ? step : {4'b0000, c};
            if (up) begin
                s = {1'b0, q_q[4*i +: 4]} + addend;
            end else begin
                s = {1'b0, q_q[4*i +: 4]} - addend;
            end
            sum[4*i +: 4] = s[3:0];
            carries[i]    = s[4];
            c             = s[4];
        end
    end

    always_comb begin
        q_d    = q_q;
        load_d = 1'b0;
        rco_d  = 1'b0;
        src_d  = '0;
        if (cnt_enable) begin
            if (mode_e'(cnt_mode) == ModeLoad) begin
                q_d    = cnt_D;
                load_d = 1'b1;
            end else begin
                src_d = carries;
                // A carry out of the top slice is exactly a whole-word wrap.
                rco_d = carries[NSLICE-1];
                if (SATURATE && carries[NSLICE-1]) begin
                    q_d = up ? '1 : '0;
                end else begin
                    q_d = sum;
                end
            end
        end
    end

    always_ff @(posedge cnt_clk or negedge cnt_reset) begin
        if (!cnt_reset) begin
            q_q    <= '0;
            load_q <= 1'b0;
            rco_q  <= 1'b0;
            src_q  <= '0;
        end else begin
            q_q    <= q_d;
            load_q <= load_d;
            rco_q  <= rco_d;
            src_q  <= src_d;
        end
    end

    assign cnt_Q    = q_q;
    assign cnt_load = load_q;
    assign cnt_rco  = rco_q;
    assign cnt_src  = src_q;

endmodule

// File: tb/tb_counter_bn.sv
// Directed bench: a 32-bit wrapping counter and a 16-bit saturating counter on one clock.
module tb_counter_bn;

    logic        clk;
    logic        rst_n;

    logic        en_a;
    logic [1:0]  mode_a;
    logic [31:0] d_a;
    logic [31:0] q_a;
    logic        load_a;
    logic        rco_a;
    logic [7:0]  src_a;

    logic        en_b;
    logic [1:0]  mode_b;
    logic [15:0] d_b;
    logic [15:0] q_b;
    logic        load_b;
    logic        rco_b;
    logic [3:0]  src_b;

    int n_checks;
    int n_pass;

    counter_bn #(.WIDTH(32), .SATURATE(1'b0)) u_wrap (
        .cnt_clk    (clk),
        .cnt_reset  (rst_n),
        .cnt_enable (en_a),
        .cnt_mode   (mode_a),
        .cnt_D      (d_a),
        .cnt_Q      (q_a),
        .cnt_load   (load_a),
        .cnt_rco    (rco_a),
        .cnt_src    (src_a)
    );

    counter_bn #(.WIDTH(16), .SATURATE(1'b1)) u_sat (
        .cnt_clk    (clk),
        .cnt_reset  (rst_n),
        .cnt_enable (en_b),
        .cnt_mode   (mode_b),
        .cnt_D      (d_b),
        .cnt_Q      (q_b),
        .cnt_load   (load_b),
        .cnt_rco    (rco_b),
        .cnt_src    (src_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_a(input logic en, input logic [1:0] mode, input logic [31:0] d);
        en_a   = en;
        mode_a = mode;
        d_a    = d;
        tick();
    endtask

    task automatic op_b(input logic en, input logic [1:0] mode, input logic [15:0] d);
        en_b   = en;
        mode_b = mode;
        d_b    = d;
        tick();
    endtask

    task automatic check_a(input string tag, input logic [31:0] q, input logic ld,
                           input logic rco, input logic [7:0] src);
        check({tag, ".q"}, q_a, q);
        check({tag, ".load"}, {31'd0, load_a}, {31'd0, ld});
        check({tag, ".rco"}, {31'd0, rco_a}, {31'd0, rco});
        check({tag, ".src"}, {24'd0, src_a}, {24'd0, src});
    endtask

    task automatic check_b(input string tag, input logic [15:0] q, input logic rco,
                           input logic [3:0] src);
        check({tag, ".q"}, {16'd0, q_b}, {16'd0, q});
        check({tag, ".rco"}, {31'd0, rco_b}, {31'd0, rco});
        check({tag, ".src"}, {28'd0, src_b}, {28'd0, src});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        en_a = 1'b0; mode_a = 2'b00; d_a = '0;
        en_b = 1'b0; mode_b = 2'b00; d_b = '0;

        #12;
        check_a("reset", 32'h0, 1'b0, 1'b0, 8'h00);
        check_b("reset_b", 16'h0, 1'b0, 4'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) op_a(1'b1, 2'b00, 32'h0);
        check_a("count5", 32'h5, 1'b0, 1'b0, 8'h00);

        // Async reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        check_a("midreset", 32'h0, 1'b0, 1'b0, 8'h00);
        #1;
        rst_n = 1'b1;
        tick();

        op_a(1'b1, 2'b11, 32'h0000FFFF);
        check_a("ld_ffff", 32'h0000FFFF, 1'b1, 1'b0, 8'h00);
        op_a(1'b1, 2'b00, 32'h0);
        check_a("carry_chain", 32'h00010000, 1'b0, 1'b0, 8'h0F);

        op_a(1'b1, 2'b11, 32'h00000010);
        op_a(1'b1, 2'b10, 32'h0);
        check_a("down3_borrow", 32'h0000000D, 1'b0, 1'b0, 8'h01);

        op_a(1'b1, 2'b11, 32'h00000001);
        op_a(1'b1, 2'b10, 32'h0);
        check_a("down3_wrap", 32'hFFFFFFFE, 1'b0, 1'b1, 8'hFF);

        op_a(1'b1, 2'b11, 32'hFFFFFFFF);
        op_a(1'b1, 2'b00, 32'h0);
        check_a("up_wrap", 32'h0, 1'b0, 1'b1, 8'hFF);
        op_a(1'b1, 2'b01, 32'h0);
        check_a("down1_wrap", 32'hFFFFFFFF, 1'b0, 1'b1, 8'hFF);

        op_a(1'b1, 2'b11, 32'h00000100);
        op_a(1'b1, 2'b01, 32'h0);
        check_a("down1_borrow", 32'h000000FF, 1'b0, 1'b0, 8'h03);

        // Disabled edges hold Q and clear flags, even with a load pending on the inputs
        for (int i = 0; i < 4; i++) begin
            op_a(1'b0, 2'b11, 32'h12345678);
            check_a("hold", 32'h000000FF, 1'b0, 1'b0, 8'h00);
        end
        op_a(1'b1, 2'b11, 32'hA5A5A5A5);
        check_a("load_a5", 32'hA5A5A5A5, 1'b1, 1'b0, 8'h00);
        op_a(1'b0, 2'b00, 32'h0);
        check_a("load_pulse", 32'hA5A5A5A5, 1'b0, 1'b0, 8'h00);

        op_b(1'b1, 2'b11, 16'hFFFF);
        check("sat_ld.load", {31'd0, load_b}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            op_b(1'b1, 2'b00, 16'h0);
            check_b("sat_up", 16'hFFFF, 1'b1, 4'hF);
        end
        op_b(1'b1, 2'b11, 16'h0001);
        op_b(1'b1, 2'b10, 16'h0);
        check_b("sat_down3", 16'h0000, 1'b1, 4'hF);
        op_b(1'b1, 2'b01, 16'h0);
        check_b("sat_down1", 16'h0000, 1'b1, 4'hF);
        op_b(1'b1, 2'b00, 16'h0);
        check_b("sat_release", 16'h0001, 1'b0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
